// File: rtl/mult_dispatch.sv
// Issue-side dispatcher for the shared mult FU: round-robin arbitration of per-thread MUL/DIV
// requests, single-DIV tracking, per-thread outstanding counters and result writeback routing.
package mult_dispatch_pkg;
  localparam int NUM_THREADS   = 2;
  localparam int XLEN          = 32;
  localparam int TRANS_ID_BITS = 3;
  localparam int THR_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHU  = 4'd2;
  localparam logic [3:0] OP_MULHSU = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;

  typedef struct packed {
    logic [3:0]               operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [THR_W-1:0]         thread_id;
  } fu_data_t;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction
endpackage

module mult_dispatch
  import mult_dispatch_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int MUL_LAT   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_THREADS-1:0]   req_valid_i,
  input  fu_data_t                 req_data_i [NUM_THREADS],
  output logic [NUM_THREADS-1:0]   req_ready_o,
  output fu_data_t                 fu_data_o,
  output logic                     mult_valid_o,
  input  logic                     mult_ready_i,
  input  logic                     res_valid_i,
  input  logic [XLEN-1:0]          res_i,
  input  logic [TRANS_ID_BITS-1:0] res_trans_id_i,
  input  logic [THR_W-1:0]         res_thread_id_i,
  output logic [NUM_THREADS-1:0]   wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NUM_THREADS-1:0]   thread_idle_o
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(MUL_LAT + 1);

  logic [CW-1:0]            r_cnt [NUM_THREADS];
  logic [THR_W-1:0]         r_rr;
  logic                     r_div_busy;
  logic [TRANS_ID_BITS-1:0] r_div_tid;
  logic [THR_W-1:0]         r_div_thr;
  logic [SW-1:0]            r_squash;

  logic [NUM_THREADS-1:0]   w_elig;
  logic [NUM_THREADS-1:0]   w_grant;
  logic [NUM_THREADS-1:0]   w_inc;
  logic [NUM_THREADS-1:0]   w_dec;
  logic [THR_W-1:0]         w_gnt_idx;
  logic                     w_gnt_any;
  logic                     w_div_free;
  logic                     w_res_acc;
  logic                     w_div_done;

  // A DIV may only start when the divider is idle and nothing DIV-class is sitting in the issue register.
  assign w_div_free = !r_div_busy && mult_ready_i && !(mult_valid_o && is_div(fu_data_o.operation));
  assign w_res_acc  = res_valid_i && !flush_i && (r_squash == '0);
  assign w_div_done = res_valid_i && r_div_busy && (res_trans_id_i == r_div_tid)
                      && (res_thread_id_i == r_div_thr);

  always_comb begin
    w_elig    = '0;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_inc     = '0;
    w_dec     = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_elig[t] = req_valid_i[t] && (r_cnt[t] < CW'(MAX_OUTST)) && !flush_i
                  && (!is_div(req_data_i[t].operation) || w_div_free);
    end
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!w_gnt_any && w_elig[(int'(r_rr) + i) % NUM_THREADS]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = THR_W'((int'(r_rr) + i) % NUM_THREADS);
      end
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_grant[t] = w_gnt_any && (w_gnt_idx == THR_W'(t));
      w_inc[t]   = w_grant[t];
      w_dec[t]   = w_res_acc && (res_thread_id_i == THR_W'(t)) && (r_cnt[t] != '0);
    end
  end

  assign req_ready_o = w_grant;

  always_comb begin
    thread_idle_o = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      thread_idle_o[t] = (r_cnt[t] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr          <= '0;
      r_div_busy    <= 1'b0;
      r_div_tid     <= '0;
      r_div_thr     <= '0;
      r_squash      <= '0;
      fu_data_o     <= '0;
      mult_valid_o  <= 1'b0;
      wb_valid_o    <= '0;
      wb_result_o   <= '0;
      wb_trans_id_o <= '0;
      for (int t = 0; t < NUM_THREADS; t++) r_cnt[t] <= '0;
    end else begin
      mult_valid_o <= w_gnt_any;
      if (w_gnt_any) begin
        fu_data_o <= req_data_i[w_gnt_idx];
        r_rr      <= THR_W'((int'(w_gnt_idx) + 1) % NUM_THREADS);
      end

      if (flush_i) begin
        r_div_busy <= 1'b0;
      end else if (w_gnt_any && is_div(req_data_i[w_gnt_idx].operation)) begin
        r_div_busy <= 1'b1;
        r_div_tid  <= req_data_i[w_gnt_idx].trans_id;
        r_div_thr  <= w_gnt_idx;
      end else if (w_div_done) begin
        r_div_busy <= 1'b0;
      end

      // Results still in the FU pipe when a flush hits belong to killed ops; drop them for MUL_LAT cycles.
      if (flush_i) r_squash <= SW'(MUL_LAT);
      else if (r_squash != '0) r_squash <= r_squash - SW'(1);

      for (int t = 0; t < NUM_THREADS; t++) begin
        if (flush_i) r_cnt[t] <= '0;
        else if (w_inc[t] && !w_dec[t]) r_cnt[t] <= r_cnt[t] + CW'(1);
        else if (w_dec[t] && !w_inc[t]) r_cnt[t] <= r_cnt[t] - CW'(1);
      end

      wb_valid_o <= '0;
      if (w_res_acc) begin
        wb_valid_o[res_thread_id_i] <= 1'b1;
        wb_result_o                 <= res_i;
        wb_trans_id_o               <= res_trans_id_i;
      end
    end
  end
endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch: a cycle-by-cycle vector table plus hand sequences for
// outstanding limit, fairness, flush/squash and asynchronous reset during a DIV.
module tb_mult_dispatch;
  import mult_dispatch_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic [NUM_THREADS-1:0]   req_valid_i;
  fu_data_t                 req_data_i [NUM_THREADS];
  logic [NUM_THREADS-1:0]   req_ready_o;
  fu_data_t                 fu_data_o;
  logic                     mult_valid_o;
  logic                     mult_ready_i;
  logic                     res_valid_i;
  logic [XLEN-1:0]          res_i;
  logic [TRANS_ID_BITS-1:0] res_trans_id_i;
  logic [THR_W-1:0]         res_thread_id_i;
  logic [NUM_THREADS-1:0]   wb_valid_o;
  logic [XLEN-1:0]          wb_result_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [NUM_THREADS-1:0]   thread_idle_o;

  int testsRun    = 0;
  int testsFailed = 0;

  mult_dispatch #(.MAX_OUTST(4), .MUL_LAT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fu_data_o(fu_data_o), .mult_valid_o(mult_valid_o), .mult_ready_i(mult_ready_i),
    .res_valid_i(res_valid_i), .res_i(res_i), .res_trans_id_i(res_trans_id_i),
    .res_thread_id_i(res_thread_id_i), .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o),
    .wb_trans_id_o(wb_trans_id_o), .thread_idle_o(thread_idle_o)
  );

  always #5 clk_i = ~clk_i;

  // One table row is one clock cycle: inputs driven, combinational ready checked, then registered outputs.
  typedef struct {
    logic [1:0]  reqValid;
    logic        div0;
    logic        div1;
    logic        multRdy;
    logic        resValid;
    logic        resThr;
    logic [2:0]  resTid;
    logic [31:0] resVal;
    logic [1:0]  expReady;
    logic        expMv;
    logic        expFuThr;
    logic [1:0]  expWb;
    logic [31:0] expWbRes;
    logic [1:0]  expIdle;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [1:0] rv, input logic d0, input logic d1, input logic mr,
                        input logic rsV, input logic rsThr, input logic [2:0] rsTid,
                        input logic [31:0] rsVal, input logic [1:0] eRdy, input logic eMv,
                        input logic eThr, input logic [1:0] eWb, input logic [31:0] eRes,
                        input logic [1:0] eIdle);
    vec_t v;
    v.reqValid = rv; v.div0 = d0; v.div1 = d1; v.multRdy = mr;
    v.resValid = rsV; v.resThr = rsThr; v.resTid = rsTid; v.resVal = rsVal;
    v.expReady = eRdy; v.expMv = eMv; v.expFuThr = eThr; v.expWb = eWb;
    v.expWbRes = eRes; v.expIdle = eIdle;
    vecs.push_back(v);
  endtask

  // Thread 0 always carries trans id 2, thread 1 trans id 5.
  task automatic applyStimulus(input logic [1:0] rv, input logic d0, input logic d1,
                               input logic mr, input logic fl, input logic rsV,
                               input logic rsThr, input logic [2:0] rsTid, input logic [31:0] rsVal);
    req_valid_i   = rv;
    req_data_i[0] = '{operation: (d0 ? OP_DIV : OP_MUL), operand_a: 32'd3, operand_b: 32'd5,
                      trans_id: 3'd2, thread_id: 1'b0};
    req_data_i[1] = '{operation: (d1 ? OP_DIV : OP_MUL), operand_a: 32'd4, operand_b: 32'd6,
                      trans_id: 3'd5, thread_id: 1'b1};
    mult_ready_i    = mr;
    flush_i         = fl;
    res_valid_i     = rsV;
    res_thread_id_i = rsThr;
    res_trans_id_i  = rsTid;
    res_i           = rsVal;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    int expG;
    int grants [2];
    int prevThr;

    rst_ni = 1'b0;
    idleInputs();
    #12;
    checkOutput("reset_ready", 64'(req_ready_o), 64'd0);
    checkOutput("reset_mv", 64'(mult_valid_o), 64'd0);
    checkOutput("reset_fu_data", 64'(fu_data_o.operand_a), 64'd0);
    checkOutput("reset_wb", 64'(wb_valid_o), 64'd0);
    checkOutput("reset_wb_res", 64'(wb_result_o), 64'd0);
    checkOutput("reset_idle", 64'(thread_idle_o), 64'd3);
    tick();
    rst_ni = 1'b1;
    tick();

    //       rv     d0 d1 mr rsV thr tid    val     eRdy  eMv eThr eWb   eRes    eIdle
    addVec(2'b01, 0, 0, 1, 0, 0, 3'd0, 32'd0,  2'b01, 1, 0, 2'b00, 32'd0,  2'b10);
    addVec(2'b00, 0, 0, 1, 1, 0, 3'd2, 32'd15, 2'b00, 0, 0, 2'b01, 32'd15, 2'b11);
    addVec(2'b11, 0, 0, 1, 0, 0, 3'd0, 32'd0,  2'b10, 1, 1, 2'b00, 32'd0,  2'b01);
    addVec(2'b11, 0, 0, 1, 0, 0, 3'd0, 32'd0,  2'b01, 1, 0, 2'b00, 32'd0,  2'b00);
    addVec(2'b11, 0, 0, 1, 1, 1, 3'd5, 32'd7,  2'b10, 1, 1, 2'b10, 32'd7,  2'b00);
    addVec(2'b11, 0, 0, 1, 1, 0, 3'd2, 32'd9,  2'b01, 1, 0, 2'b01, 32'd9,  2'b00);
    addVec(2'b00, 0, 0, 1, 1, 0, 3'd2, 32'd11, 2'b00, 0, 0, 2'b01, 32'd11, 2'b01);
    addVec(2'b00, 0, 0, 1, 1, 1, 3'd5, 32'd13, 2'b00, 0, 0, 2'b10, 32'd13, 2'b11);
    addVec(2'b01, 1, 0, 1, 0, 0, 3'd0, 32'd0,  2'b01, 1, 0, 2'b00, 32'd0,  2'b10);
    addVec(2'b10, 0, 1, 1, 0, 0, 3'd0, 32'd0,  2'b00, 0, 0, 2'b00, 32'd0,  2'b10);
    addVec(2'b10, 0, 1, 1, 1, 0, 3'd2, 32'd4,  2'b00, 0, 0, 2'b01, 32'd4,  2'b11);
    addVec(2'b10, 0, 1, 1, 0, 0, 3'd0, 32'd0,  2'b10, 1, 1, 2'b00, 32'd0,  2'b01);
    addVec(2'b00, 0, 0, 1, 1, 1, 3'd5, 32'd8,  2'b00, 0, 0, 2'b10, 32'd8,  2'b11);
    addVec(2'b01, 1, 0, 0, 0, 0, 3'd0, 32'd0,  2'b00, 0, 0, 2'b00, 32'd0,  2'b11);
    addVec(2'b01, 1, 0, 1, 0, 0, 3'd0, 32'd0,  2'b01, 1, 0, 2'b00, 32'd0,  2'b10);
    addVec(2'b10, 0, 1, 1, 1, 0, 3'd3, 32'd6,  2'b00, 0, 0, 2'b01, 32'd6,  2'b11);
    addVec(2'b10, 0, 1, 1, 0, 0, 3'd0, 32'd0,  2'b00, 0, 0, 2'b00, 32'd0,  2'b11);
    addVec(2'b10, 0, 1, 1, 1, 0, 3'd2, 32'd6,  2'b00, 0, 0, 2'b01, 32'd6,  2'b11);
    addVec(2'b10, 0, 1, 1, 0, 0, 3'd0, 32'd0,  2'b10, 1, 1, 2'b00, 32'd0,  2'b01);
    addVec(2'b00, 0, 0, 1, 1, 1, 3'd5, 32'd21, 2'b00, 0, 0, 2'b10, 32'd21, 2'b11);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reqValid, vecs[i].div0, vecs[i].div1, vecs[i].multRdy, 1'b0,
                    vecs[i].resValid, vecs[i].resThr, vecs[i].resTid, vecs[i].resVal);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 64'(req_ready_o), 64'(vecs[i].expReady));
      tick();
      checkOutput($sformatf("vec%0d_mv", i), 64'(mult_valid_o), 64'(vecs[i].expMv));
      if (vecs[i].expMv)
        checkOutput($sformatf("vec%0d_fu_thr", i), 64'(fu_data_o.thread_id), 64'(vecs[i].expFuThr));
      checkOutput($sformatf("vec%0d_wb", i), 64'(wb_valid_o), 64'(vecs[i].expWb));
      if (vecs[i].expWb != 2'b00)
        checkOutput($sformatf("vec%0d_wb_res", i), 64'(wb_result_o), 64'(vecs[i].expWbRes));
      checkOutput($sformatf("vec%0d_idle", i), 64'(thread_idle_o), 64'(vecs[i].expIdle));
    end

    // Outstanding limit: rr is 0 here; four MULs fill thread 0, the fifth waits for a result.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
      #1;
      checkOutput($sformatf("outst_grant%0d", k), 64'(req_ready_o), 64'd1);
      tick();
    end
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    checkOutput("outst_blocked", 64'(req_ready_o), 64'd0);
    tick();
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'd1);
    #1;
    checkOutput("outst_blocked_res", 64'(req_ready_o), 64'd0);
    tick();
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    checkOutput("outst_fifth", 64'(req_ready_o), 64'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'(k));
      tick();
    end
    idleInputs();
    tick();
    checkOutput("outst_drained_idle", 64'(thread_idle_o), 64'd3);

    // Fairness: rr is 1 after the last thread-0 grant; results retire the previous grant each cycle.
    expG = 1;
    prevThr = 0;
    grants[0] = 0;
    grants[1] = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, (k > 0), prevThr[0], 3'd0, 32'(k));
      #1;
      checkOutput($sformatf("rr_grant%0d", k), 64'(req_ready_o), 64'(1 << expG));
      if (req_ready_o == 2'b01) grants[0]++;
      if (req_ready_o == 2'b10) grants[1]++;
      prevThr = expG;
      expG = 1 - expG;
      tick();
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, prevThr[0], 3'd0, 32'd0);
    tick();
    idleInputs();
    tick();
    checkOutput("rr_t0_count", 64'(grants[0]), 64'd8);
    checkOutput("rr_t1_count", 64'(grants[1]), 64'd8);
    checkOutput("rr_idle", 64'(thread_idle_o), 64'd3);

    // Flush with one MUL per thread in flight; coincident and squash-window results are dropped.
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    checkOutput("flush_pre_idle", 64'(thread_idle_o), 64'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'd77);
    #1;
    checkOutput("flush_ready", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("flush_mv", 64'(mult_valid_o), 64'd0);
    checkOutput("flush_wb_coincident", 64'(wb_valid_o), 64'd0);
    checkOutput("flush_idle", 64'(thread_idle_o), 64'd3);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 32'd78);
    tick();
    checkOutput("flush_wb_squash", 64'(wb_valid_o), 64'd0);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'd79);
    tick();
    checkOutput("flush_reload_wb", 64'(wb_valid_o), 64'd0);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    checkOutput("flush_after_ready", 64'(req_ready_o), 64'd1);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'd42);
    tick();
    checkOutput("flush_after_wb", 64'(wb_valid_o), 64'd1);
    checkOutput("flush_after_res", 64'(wb_result_o), 64'd42);
    checkOutput("flush_after_idle", 64'(thread_idle_o), 64'd3);

    // Asynchronous reset while a DIV is outstanding and a writeback is visible.
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    applyStimulus(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 32'd99);
    #1;
    checkOutput("rst_div_blocked", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("rst_pre_wb", 64'(wb_valid_o), 64'd2);
    idleInputs();
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid_mv", 64'(mult_valid_o), 64'd0);
    checkOutput("rst_mid_wb", 64'(wb_valid_o), 64'd0);
    checkOutput("rst_mid_wb_res", 64'(wb_result_o), 64'd0);
    checkOutput("rst_mid_idle", 64'(thread_idle_o), 64'd3);
    tick();
    rst_ni = 1'b1;
    tick();
    applyStimulus(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    checkOutput("rst_after_div_ready", 64'(req_ready_o), 64'd2);
    tick();
    checkOutput("rst_after_mv", 64'(mult_valid_o), 64'd1);
    checkOutput("rst_after_fu_thr", 64'(fu_data_o.thread_id), 64'd1);
    idleInputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
